// File: rtl/intc_multi.sv
// Multi-channel interrupt controller: latches done events with per-channel enable and
// edge/level mode, and raises the lowest-index pending channel through a req/ack/EOI handshake.
//   state  | meaning
//   S_IDLE | no request outstanding; latch the winning channel when one is selectable
//   S_REQ  | irq high for the latched channel, waiting for iack or withdrawal
//   S_SVC  | processor servicing the channel; waiting for an EOI write to CTRL
module intc_multi #(
  parameter int NUM_IRQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] done,
  input  logic               iack,
  input  logic [31:0]        input_addr,
  input  logic               write_enable,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               irq,
  output logic [DATA_W-1:0]  isr_addr,
  output logic [4:0]         irq_id
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  localparam logic [5:0] NUM6 = 6'(NUM_IRQ);

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] enable, mode, pending, pending_d, done_q;
  logic [DATA_W-1:0]  isr_reg [NUM_IRQ];
  logic               in_service;
  logic               irq_q;

  logic [7:0]         addr;
  logic [5:0]         isr_idx;
  logic               hit_isr;
  logic               wr_enable, wr_mode, wr_pending, wr_ctrl;
  logic [NUM_IRQ-1:0] w1c;

  logic [NUM_IRQ-1:0] cur_mask;
  logic               cur_active;
  logic               sel_valid;
  logic [4:0]         sel_id;
  logic [DATA_W-1:0]  sel_addr;
  logic               latch, ack, eoi;

  logic unused_addr;
  assign unused_addr = ^input_addr[31:8];

  // Address decode; every register is word aligned.
  assign addr       = input_addr[7:0];
  assign isr_idx    = addr[7:2] - 6'd16;
  assign hit_isr    = (addr[1:0] == 2'b00) && (addr[7:2] >= 6'd16) && (isr_idx < NUM6);
  assign wr_enable  = write_enable && (addr == 8'h00);
  assign wr_mode    = write_enable && (addr == 8'h04);
  assign wr_pending = write_enable && (addr == 8'h08);
  assign wr_ctrl    = write_enable && (addr == 8'h0C);
  assign w1c        = wr_pending ? write_data[NUM_IRQ-1:0] : '0;

  always_comb begin
    read_data = '0;
    if (addr == 8'h00) begin
      read_data[NUM_IRQ-1:0] = enable;
    end else if (addr == 8'h04) begin
      read_data[NUM_IRQ-1:0] = mode;
    end else if (addr == 8'h08) begin
      read_data[NUM_IRQ-1:0] = pending;
    end else if (addr == 8'h0C) begin
      read_data[DATA_W-1] = in_service;
      read_data[4:0]      = irq_id;
    end else if (hit_isr) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (isr_idx == 6'(i)) read_data = isr_reg[i];
      end
    end
  end

  // Priority select: scanning downward leaves the lowest selectable index.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    sel_addr  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i] && enable[i]) begin
        sel_valid = 1'b1;
        sel_id    = 5'(i);
        sel_addr  = isr_reg[i];
      end
    end
  end

  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      cur_mask[i] = (irq_id == 5'(i));
    end
  end

  assign cur_active = |(pending & enable & cur_mask);

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    ack     = 1'b0;
    eoi     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          latch   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (iack) begin
          ack     = 1'b1;
          state_d = S_SVC;
        end else if (!cur_active) begin
          state_d = S_IDLE;
        end
      end
      S_SVC: begin
        if (wr_ctrl) begin
          eoi     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge channels: a fresh set beats a same-cycle W1C or acknowledge clear.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode[i]) begin
        pending_d[i] = (done[i] & ~done_q[i] & enable[i]) |
                       (pending[i] & ~(w1c[i] | (ack & cur_mask[i])));
      end else begin
        pending_d[i] = done[i] & enable[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      irq_q      <= 1'b0;
      isr_addr   <= '0;
      irq_id     <= '0;
      in_service <= 1'b0;
      pending    <= '0;
      done_q     <= '0;
      enable     <= '0;
      mode       <= '1;
      for (int i = 0; i < NUM_IRQ; i++) isr_reg[i] <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d == S_REQ);
      pending <= pending_d;
      done_q  <= done;
      if (latch) begin
        isr_addr <= sel_addr;
        irq_id   <= sel_id;
      end
      if (ack)      in_service <= 1'b1;
      else if (eoi) in_service <= 1'b0;
      if (wr_enable) enable <= write_data[NUM_IRQ-1:0];
      if (wr_mode)   mode   <= write_data[NUM_IRQ-1:0];
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (write_enable && hit_isr && (isr_idx == 6'(i))) isr_reg[i] <= write_data;
      end
    end
  end

  assign irq = irq_q;

endmodule
